// File: rtl/stim_sweep_gen.sv
// Stimulus sequencer: sweeps every packed input vector in binary, Gray or LFSR order,
// holding each for a programmable number of cycles and folding the DUT response into a MISR.
module stim_sweep_gen #(
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 2,
  parameter int RESP_W     = 3,
  parameter int HOLD_W     = 8,
  localparam int VEC_W     = NUM_FIELDS * FIELD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold,
  input  logic [RESP_W-1:0] resp,
  output logic [VEC_W-1:0]  stim,
  output logic              stim_valid,
  output logic              busy,
  output logic              done,
  output logic [VEC_W:0]    vec_cnt,
  output logic [15:0]       signature
);

  localparam int CNT_W = VEC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {ORD_BIN, ORD_GRAY, ORD_LFSR} order_t;

  // Maximal-length Fibonacci taps (XAPP052), bit t-1 set for tap t.
  function automatic logic [VEC_W-1:0] tap_mask(input int w);
    logic [15:0] m;
    case (w)
      2:       m = 16'h0003;
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m[VEC_W-1:0];
  endfunction

  localparam logic [VEC_W-1:0] TAPS      = tap_mask(VEC_W);
  localparam logic [VEC_W-1:0] LAST_BIN  = {VEC_W{1'b1}};
  localparam logic [VEC_W-1:0] LAST_LFSR = {{(VEC_W-1){1'b1}}, 1'b0};
  localparam logic [VEC_W-1:0] LFSR_SEED = {{(VEC_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  order_t            order_q, start_order;
  logic [HOLD_W-1:0] hold_m1, hold_cnt, hold_m1_start;
  logic [VEC_W-1:0]  idx, idx_inc, next_vec, start_vec;
  logic [15:0]       resp_ext, sig_nxt;
  logic              hold_last, last_vec, sample;

  // Decode of the controller inputs used only at the start edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    start_order = ORD_BIN;
    case (mode)
      2'b01:   start_order = ORD_GRAY;
      2'b10:   start_order = ORD_LFSR;
      default: start_order = ORD_BIN;
    endcase
    start_vec     = (start_order == ORD_LFSR) ? LFSR_SEED : '0;
    hold_m1_start = (hold == '0) ? '0 : hold - HOLD_W'(1);
  end

  // Sequence stepping and end-of-vector detection.
  always_comb begin
    idx_inc  = idx + VEC_W'(1);
    next_vec = idx_inc;
    case (order_q)
      ORD_GRAY: next_vec = idx_inc ^ (idx_inc >> 1);
      ORD_LFSR: next_vec = {stim[VEC_W-2:0], ^(stim & TAPS)};
      default:  next_vec = idx_inc;
    endcase
    last_vec  = (idx == ((order_q == ORD_LFSR) ? LAST_LFSR : LAST_BIN));
    hold_last = (hold_cnt == hold_m1);
    sample    = (state == S_RUN) && !abort && hold_last;
  end

  always_comb begin
    resp_ext               = '0;
    resp_ext[RESP_W-1:0]   = resp;
    sig_nxt = {signature[14:0], signature[15] ^ signature[11] ^ signature[4]} ^ resp_ext;
  end

  // FSM next state and status outputs.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    stim_valid = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy       = 1'b1;
        stim_valid = 1'b1;
        if (abort)                 state_nxt = S_IDLE;
        else if (sample && last_vec) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath: abort freezes the counters and MISR on its edge, even on the final sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim      <= '0;
      idx       <= '0;
      hold_cnt  <= '0;
      hold_m1   <= '0;
      order_q   <= ORD_BIN;
      vec_cnt   <= '0;
      signature <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            order_q   <= start_order;
            hold_m1   <= hold_m1_start;
            stim      <= start_vec;
            idx       <= '0;
            hold_cnt  <= '0;
            vec_cnt   <= '0;
            signature <= 16'hFFFF;
          end
        end
        S_RUN: begin
          if (sample) begin
            signature <= sig_nxt;
            vec_cnt   <= vec_cnt + CNT_W'(1);
            hold_cnt  <= '0;
            if (!last_vec) begin
              idx  <= idx_inc;
              stim <= next_vec;
            end
          end else if (!abort) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sweep_gen.sv
// Directed bench for stim_sweep_gen: sequence order, hold timing, abort, reset and MISR
// against a bench-side model of a 2-bit adder DUT (resp = field0 + field1).
module tb_stim_sweep_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, force_en;
  logic [1:0]  mode;
  logic [7:0]  hold;
  logic [2:0]  resp;
  logic [7:0]  stim;
  logic        stim_valid, busy, done;
  logic [8:0]  vec_cnt;
  logic [15:0] signature;

  logic [7:0]  exp_arr [256];
  int          n_exp;
  int          n_cmp, n_bad;

  stim_sweep_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .hold(hold),
    .resp(resp), .stim(stim), .stim_valid(stim_valid), .busy(busy), .done(done),
    .vec_cnt(vec_cnt), .signature(signature)
  );

  always #5 clk = ~clk;

  // Combinational DUT stand-in, optionally with resp[0] stuck high.
  always_comb begin
    resp = {1'b0, stim[1:0]} + {1'b0, stim[3:2]};
    if (force_en) resp[0] = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build_exp(input logic [1:0] m);
    logic [7:0] s, b;
    s     = 8'h01;
    n_exp = (m == 2'b10) ? 255 : 256;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      case (m)
        2'b01:   exp_arr[i] = b ^ (b >> 1);
        2'b10: begin
          exp_arr[i] = s;
          s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        default: exp_arr[i] = b;
      endcase
    end
  endfunction

  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] sig;
    logic [7:0]  v;
    logic [2:0]  r;
    sig = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      v = exp_arr[i];
      r = {1'b0, v[1:0]} + {1'b0, v[3:2]};
      if (force_en) r[0] = 1'b1;
      sig = {sig[14:0], sig[15] ^ sig[11] ^ sig[4]} ^ {13'd0, r};
    end
    return sig;
  endfunction

  // Full sweep; counts deviations from the expected per-cycle stream. A second start
  // mid-run and one in the DONE cycle must both be ignored.
  task automatic do_sweep(input logic [1:0] m, input logic [7:0] h, output int done_cyc,
                          output int seq_err, output int prop_err, output logic [15:0] sig_first,
                          output logic post_busy);
    int         he, v;
    logic [7:0] prev;
    bit         seen [256];
    he = (h == 8'd0) ? 1 : int'(h);
    build_exp(m);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    done_cyc = -1; seq_err = 0; prop_err = 0; sig_first = '0; prev = '0;
    @(negedge clk);
    mode = m; hold = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n_exp * he + 8; k++) begin
      start = (k == 5);
      if (k == 1) sig_first = signature;
      if (done) begin
        done_cyc = k;
        if (busy || stim_valid || stim !== exp_arr[n_exp-1] || vec_cnt !== 9'(n_exp)) seq_err++;
        break;
      end
      v = (k - 1) / he;
      if (v >= n_exp) seq_err++;
      else if (!busy || !stim_valid || stim !== exp_arr[v] || vec_cnt !== 9'(v)) seq_err++;
      if (k == 1 || stim != prev) begin
        if (m == 2'b01 && k > 1 && $countones(stim ^ prev) != 1) prop_err++;
        if (m == 2'b10) begin
          if (stim == 8'h00 || seen[stim]) prop_err++;
          seen[stim] = 1'b1;
        end
      end
      prev = stim;
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    post_busy = busy | done;
    start = 1'b0;
  endtask

  // Start (with abort raised in the same cycle), then abort while cycle k_ab is live.
  task automatic abort_run(input logic [1:0] m, input logic [7:0] h, input int k_ab,
                           output logic [7:0] stim_ab, output logic busy1);
    @(negedge clk);
    mode = m; hold = h; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    busy1 = busy;
    for (int k = 1; k < k_ab; k++) @(negedge clk);
    stim_ab = stim;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    int          dc, se, pe, dn;
    logic [15:0] sf, sig_bin;
    logic        pb, b1;
    logic [7:0]  sa;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; hold = 8'd1; force_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stim", stim, 0);
    check("rst_valid", stim_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec_cnt", vec_cnt, 0);
    check("rst_sig", signature, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort while stim = 10: vectors 0..9 sampled, nothing more.
    build_exp(2'b00);
    abort_run(2'b00, 8'd1, 11, sa, b1);
    check("abort_start_wins", b1, 1);
    check("abort_stim", sa, 8'd10);
    check("abort_busy", busy, 0);
    check("abort_valid", stim_valid, 0);
    check("abort_done", done, 0);
    check("abort_vec_cnt", vec_cnt, 10);
    check("abort_sig", signature, model_sig(10));
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_sig_frozen", signature, model_sig(10));
    check("abort_cnt_frozen", vec_cnt, 10);

    // Binary, hold 1 (also the restart after abort).
    do_sweep(2'b00, 8'd1, dc, se, pe, sf, pb);
    sig_bin = model_sig(256);
    check("bin_done_cyc", dc, 257);
    check("bin_seq", se, 0);
    check("bin_restart_sig", sf, 16'hFFFF);
    check("bin_start_in_done_ignored", pb, 0);
    check("bin_sig", signature, sig_bin);
    check("bin_vec_cnt", vec_cnt, 256);
    check("bin_last_stim", stim, 8'hFF);
    repeat (3) @(negedge clk);
    check("bin_sig_stable", signature, sig_bin);

    // Gray.
    do_sweep(2'b01, 8'd1, dc, se, pe, sf, pb);
    check("gray_done_cyc", dc, 257);
    check("gray_seq", se, 0);
    check("gray_one_bit", pe, 0);
    check("gray_last_stim", stim, 8'h80);
    check("gray_sig", signature, model_sig(256));

    // LFSR.
    do_sweep(2'b10, 8'd1, dc, se, pe, sf, pb);
    check("lfsr_done_cyc", dc, 256);
    check("lfsr_seq", se, 0);
    check("lfsr_distinct_nonzero", pe, 0);
    check("lfsr_vec_cnt", vec_cnt, 255);
    check("lfsr_sig", signature, model_sig(255));

    // Hold 3: one sample per vector, so signature equals the hold-1 binary one.
    do_sweep(2'b00, 8'd3, dc, se, pe, sf, pb);
    check("hold3_done_cyc", dc, 769);
    check("hold3_seq", se, 0);
    check("hold3_sig", signature, sig_bin);

    do_sweep(2'b00, 8'd0, dc, se, pe, sf, pb);
    check("hold0_done_cyc", dc, 257);
    check("hold0_seq", se, 0);
    check("hold0_sig", signature, sig_bin);

    do_sweep(2'b11, 8'd1, dc, se, pe, sf, pb);
    check("mode3_done_cyc", dc, 257);
    check("mode3_seq", se, 0);

    // Stuck response bit must change the signature.
    force_en = 1'b1;
    do_sweep(2'b00, 8'd1, dc, se, pe, sf, pb);
    check("forced_sig", signature, model_sig(256));
    check("forced_sig_differs", signature != sig_bin, 1);
    force_en = 1'b0;

    // Abort on the final sample edge.
    build_exp(2'b00);
    abort_run(2'b00, 8'd1, 256, sa, b1);
    check("final_abort_stim", sa, 8'hFF);
    check("final_abort_done", done, 0);
    check("final_abort_busy", busy, 0);
    check("final_abort_vec_cnt", vec_cnt, 255);
    check("final_abort_sig", signature, model_sig(255));

    // Reset mid-sweep.
    @(negedge clk);
    mode = 2'b10; hold = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_stim", stim, 0);
    check("midrst_valid", stim_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_vec_cnt", vec_cnt, 0);
    check("midrst_sig", signature, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
